imem_loader: RTL

- Writer side of the 64 x 32-bit instruction memory: fills it from a byte stream before the processor runs.
- Takes a byte stream on a valid/ready handshake and packs 4 bytes, big-endian, into one instruction word.
- Issues one write per word on a write port that drives the memory's write side; the fetch side reads the memory through its 6-bit address.
- Sits between a host/UART byte source and the instruction memory; the processor is held off until Done.

---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_loader_if.sv | 27 ++
 rtl/byte_packer.sv | 35 +++
 rtl/imem_loader.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared sizing and loader state encoding for the instruction-memory loader.
package imem_pkg;

   localparam int IMEM_ADDR_WIDTH = 6;
   localparam int IMEM_DATA_WIDTH = 32;
   localparam int IMEM_DEPTH      = 1 << IMEM_ADDR_WIDTH;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_WRITE   = 3'd2,
      ST_CHECK   = 3'd3,
      ST_DONE    = 3'd4
   } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and memory write port of the loader, bundled with
// master (loader side) and slave (source/memory side) modports.
interface imem_loader_if
   import imem_pkg::*;
#(
   parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
   parameter int DATA_WIDTH = IMEM_DATA_WIDTH
);

   logic [7:0]            ByteIn;
   logic                  ByteValid;
   logic                  ByteReady;
   logic                  WriteEnable;
   logic [ADDR_WIDTH-1:0] WriteAddress;
   logic [DATA_WIDTH-1:0] WriteData;

   modport master (
      input  ByteIn, ByteValid,
      output ByteReady, WriteEnable, WriteAddress, WriteData
   );

   modport slave (
      output ByteIn, ByteValid,
      input  ByteReady, WriteEnable, WriteAddress, WriteData
   );

endinterface

// File: rtl/byte_packer.sv
// Shifts bytes in MSB-first into a word; WordFull flags the byte that completes it.
module byte_packer
   import imem_pkg::*;
#(
   parameter int DATA_WIDTH = IMEM_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  Clear,
   input  logic                  ShiftEn,
   input  logic [7:0]            ByteIn,
   output logic                  WordFull,
   output logic [DATA_WIDTH-1:0] Word
);

   localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
   localparam int CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

   logic [CNT_W-1:0] byte_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || Clear) begin
         byte_cnt <= '0;
         Word     <= '0;
      end else if (ShiftEn) begin
         Word     <= {Word[DATA_WIDTH-9:0], ByteIn};
         byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + CNT_W'(1);
      end
   end

   // Asserted in the cycle the completing byte is being accepted
   assign WordFull = ShiftEn && (byte_cnt == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a byte stream into words and writes them out.
// Optional trailing checksum word enabled by IMEM_LOADER_CHECKSUM_EN.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for Start after reset
// ST_COLLECT | accepting bytes of the current word
// ST_WRITE   | one-cycle write strobe for the packed word
// ST_CHECK   | accepting the 4 checksum bytes (checksum build only)
// ST_DONE    | load complete, Done held until the next Start
module imem_loader
   import imem_pkg::*;
#(
   parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
   parameter int DATA_WIDTH = IMEM_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  Start,
   input  logic [ADDR_WIDTH-1:0] StartAddress,
   input  logic [ADDR_WIDTH:0]   WordCount,
   imem_loader_if.master         bus,
   output logic                  Busy,
   output logic                  Done,
   output logic                  ChecksumOk
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam loader_state_t FINAL_ST = ST_CHECK;
`else
   localparam loader_state_t FINAL_ST = ST_DONE;
`endif

   loader_state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [ADDR_WIDTH:0]   words_left;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic [DATA_WIDTH-1:0] word;
   logic                  word_full;
   logic                  accept;
   logic                  start_take;
   logic                  byte_ready;
   logic                  write_enable;
   logic                  last_word;

   assign accept    = bus.ByteValid && byte_ready;
   assign last_word = (words_left == (ADDR_WIDTH+1)'(1));

   byte_packer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_packer (
      .clk      (clk),
      .rst_n    (rst_n),
      .Clear    (start_take),
      .ShiftEn  (accept),
      .ByteIn   (bus.ByteIn),
      .WordFull (word_full),
      .Word     (word)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      start_take   = 1'b0;
      byte_ready   = 1'b0;
      write_enable = 1'b0;
      Busy         = 1'b0;
      Done         = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            Done = (state == ST_DONE);
            if (Start) begin
               start_take = 1'b1;
               state_nxt  = (WordCount == '0) ? FINAL_ST : ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            Busy       = 1'b1;
            byte_ready = 1'b1;
            if (word_full) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            Busy         = 1'b1;
            write_enable = 1'b1;
            state_nxt    = last_word ? FINAL_ST : ST_COLLECT;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            Busy       = 1'b1;
            byte_ready = 1'b1;
            if (word_full) state_nxt = ST_DONE;
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr       <= '0;
         words_left <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         if (start_take) begin
            addr       <= StartAddress;
            words_left <= WordCount;
         end
         if (state == ST_WRITE) begin
            wr_addr_q  <= addr;
            wr_data_q  <= word;
            addr       <= addr + ADDR_WIDTH'(1);
            words_left <= words_left - (ADDR_WIDTH+1)'(1);
         end
      end
   end

   // Write port shows the live word during the strobe, then holds it
   assign bus.ByteReady    = byte_ready;
   assign bus.WriteEnable  = write_enable;
   assign bus.WriteAddress = (state == ST_WRITE) ? addr : wr_addr_q;
   assign bus.WriteData    = (state == ST_WRITE) ? word : wr_data_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] xor_acc;
   logic                  checksum_ok;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xor_acc     <= '0;
         checksum_ok <= 1'b1;
      end else begin
         if (start_take) begin
            xor_acc     <= '0;
            checksum_ok <= 1'b0;
         end
         if (state == ST_WRITE) xor_acc <= xor_acc ^ word;
         if (state == ST_CHECK && word_full)
            checksum_ok <= ({word[DATA_WIDTH-9:0], bus.ByteIn} == xor_acc);
      end
   end

   assign ChecksumOk = checksum_ok;
`else
   assign ChecksumOk = 1'b1;
`endif

endmodule
